// File: rtl/adder_disp_pkg.sv
// Shared types and segment encodings for the adder result display.
// Segment vectors are ordered {g,f,e,d,c,b,a}, active-high.
package adder_disp_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHold = 2'd1,
        StShow = 2'd2
    } disp_state_e;

    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        hex_to_seg = SEG_BLANK;
        case (v)
            4'h0: hex_to_seg = 7'h3F;
            4'h1: hex_to_seg = 7'h06;
            4'h2: hex_to_seg = 7'h5B;
            4'h3: hex_to_seg = 7'h4F;
            4'h4: hex_to_seg = 7'h66;
            4'h5: hex_to_seg = 7'h6D;
            4'h6: hex_to_seg = 7'h7D;
            4'h7: hex_to_seg = 7'h07;
            4'h8: hex_to_seg = 7'h7F;
            4'h9: hex_to_seg = 7'h6F;
            4'hA: hex_to_seg = 7'h77;
            4'hB: hex_to_seg = 7'h7C;
            4'hC: hex_to_seg = 7'h39;
            4'hD: hex_to_seg = 7'h5E;
            4'hE: hex_to_seg = 7'h79;
            4'hF: hex_to_seg = 7'h71;
            default: hex_to_seg = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/disp_tick_gen.sv
// Free-running 0..MAX_COUNT-1 divider producing a one-cycle tick at the top count.
// A synchronous clear restarts the period and suppresses the tick on that cycle.
module disp_tick_gen #(
    parameter int unsigned MAX_COUNT = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (MAX_COUNT > 2) ? $clog2(MAX_COUNT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_max;

    assign at_max = (cnt_q == CNT_W'(MAX_COUNT - 1));
    assign tick   = ena && at_max && !clr;

    always_comb begin
        cnt_d = cnt_q;
        if (ena) begin
            if (clr || at_max) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/adder_result_display.sv
// Accepts adder results over valid/ready and shows them as a hex digit, holding each
// for a minimum number of ticks and blinking the digit when the carry bit is set.
module adder_result_display
    import adder_disp_pkg::*;
#(
    parameter int unsigned MAX_COUNT  = 10_000_000,
    parameter int unsigned HOLD_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       res_valid,
    input  logic [2:0] res_sum,
    input  logic       res_cout,
    output logic       res_ready,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] cap_cnt
);

    localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 2);

    disp_state_e       state_q, state_d;
    logic [3:0]        val_q, val_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              blink_q, blink_d;
    logic [3:0]        cap_q, cap_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic              capture;
    logic              tick;

    assign res_ready = ena && (state_q != StHold);
    assign capture   = res_valid && res_ready;

    disp_tick_gen #(
        .MAX_COUNT(MAX_COUNT)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .ena  (ena),
        .clr  (capture),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        hold_d  = hold_q;
        blink_d = blink_q;
        cap_d   = cap_q;
        if (capture) begin
            val_d   = {res_cout, res_sum};
            cap_d   = cap_q + 4'd1;
            hold_d  = HOLD_W'(HOLD_TICKS);
            blink_d = 1'b1;
            state_d = (HOLD_TICKS == 0) ? StShow : StHold;
        end else if (tick) begin
            if (state_q == StHold) begin
                hold_d = hold_q - HOLD_W'(1);
                if (hold_q == HOLD_W'(1)) begin
                    state_d = StShow;
                end
            end
            // Only carry-set results blink; others keep blink_q at 1.
            if (state_q != StIdle && val_q[3]) begin
                blink_d = !blink_q;
            end
        end

        // Outputs are registered from next-state so they track captures one cycle later.
        if (state_d == StIdle) begin
            seg_d = SEG_DASH;
        end else if (blink_d) begin
            seg_d = hex_to_seg(val_d);
        end else begin
            seg_d = SEG_BLANK;
        end
        dp_d = (state_d == StHold);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            val_q   <= 4'd0;
            hold_q  <= '0;
            blink_q <= 1'b1;
            cap_q   <= 4'd0;
            seg_q   <= SEG_DASH;
            dp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            hold_q  <= hold_d;
            blink_q <= blink_d;
            cap_q   <= cap_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign seg     = seg_q;
    assign dp      = dp_q;
    assign cap_cnt = cap_q;

endmodule
